// File: rtl/cp0_pkg.sv
// cp0 shared constants: register addresses, field positions, PRID.
// Imported by cp0 and cp0_timer.
package cp0_pkg;

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_SR      = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_PRID    = 5'd15;

  localparam int IM_LO   = 10;
  localparam int IM_HI   = 15;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;
  localparam int IP_LO   = 10;
  localparam int IP_HI   = 15;
  localparam int TI_BIT  = 30;

  localparam logic [31:0] PRID_VAL = 32'h1830_0001;

endpackage

// File: rtl/cp0_timer.sv
// cp0 timer: free-running COUNT, COMPARE, and sticky TI flag.
// Ports: clk, rst (async low), we_count, we_compare, din -> count, compare, ti.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_count,
  input  logic        we_compare,
  input  logic [31:0] din,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;
  logic        w_match;

  // COMPARE of zero disables the timer
  assign w_match = (r_count == r_compare) && (r_compare != 32'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_ti      <= 1'b0;
    end else begin
      if (we_count) r_count <= din;
      else          r_count <= r_count + 32'd1;
      if (we_compare) r_compare <= din;
      // a COMPARE write acknowledges the timer, even on a match cycle
      if (we_compare)   r_ti <= 1'b0;
      else if (w_match) r_ti <= 1'b1;
    end
  end

  assign count   = r_count;
  assign compare = r_compare;
  assign ti      = r_ti;

endmodule

// File: rtl/cp0.sv
// cp0: SR, CAUSE, EPC, PRID, timer, mfc0/mtc0 port, interrupt request.
// Ports: clk, rst, cp0_addr, din, cp0_we, exlset, exlclr, pc, hwint -> dout, epc, int_req.
module cp0
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] din,
  input  logic        cp0_we,
  input  logic        exlset,
  input  logic        exlclr,
  input  logic [31:0] pc,
  input  logic [5:0]  hwint,
  output logic [31:0] dout,
  output logic [31:0] epc,
  output logic        int_req
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic [5:0]  r_ip;
  logic [31:0] r_epc;

  logic        w_we_sr;
  logic        w_we_epc;
  logic        w_we_count;
  logic        w_we_compare;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic [31:0] w_dout;
  logic        w_unused;

  assign w_we_sr      = cp0_we && (cp0_addr == ADDR_SR);
  assign w_we_epc     = cp0_we && (cp0_addr == ADDR_EPC);
  assign w_we_count   = cp0_we && (cp0_addr == ADDR_COUNT);
  assign w_we_compare = cp0_we && (cp0_addr == ADDR_COMPARE);

  // EPC is word aligned; the low pc bits are dropped
  assign w_unused = ^pc[1:0];

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .we_count   (w_we_count),
    .we_compare (w_we_compare),
    .din        (din),
    .count      (w_count),
    .compare    (w_compare),
    .ti         (w_ti)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_im  <= 6'd0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
      r_ip  <= 6'd0;
      r_epc <= 32'd0;
    end else begin
      // timer shares the top hardware line
      r_ip <= hwint | {w_ti, 5'b0};
      if (w_we_sr) begin
        r_im <= din[IM_HI:IM_LO];
        r_ie <= din[IE_BIT];
      end
      if (exlset)       r_exl <= 1'b1;
      else if (exlclr)  r_exl <= 1'b0;
      else if (w_we_sr) r_exl <= din[EXL_BIT];
      if (exlset)        r_epc <= {pc[31:2], 2'b00};
      else if (w_we_epc) r_epc <= din;
    end
  end

  always_comb begin
    w_dout = 32'd0;
    case (cp0_addr)
      ADDR_COUNT:   w_dout = w_count;
      ADDR_COMPARE: w_dout = w_compare;
      ADDR_SR: begin
        w_dout[IM_HI:IM_LO] = r_im;
        w_dout[EXL_BIT]     = r_exl;
        w_dout[IE_BIT]      = r_ie;
      end
      ADDR_CAUSE: begin
        w_dout[TI_BIT]      = w_ti;
        w_dout[IP_HI:IP_LO] = r_ip;
      end
      ADDR_EPC:  w_dout = r_epc;
      ADDR_PRID: w_dout = PRID_VAL;
      default:   w_dout = 32'd0;
    endcase
  end

  assign dout    = w_dout;
  assign epc     = r_epc;
  assign int_req = r_ie & ~r_exl & |(r_ip & r_im);

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 for the multi-cycle MIPS core: holds the status, cause, EPC, processor-ID and count/compare registers, serves mfc0/mtc0 through a single read/write port, samples six hardware interrupt lines plus an internal timer, and raises the interrupt request the core's controller polls at instruction boundaries. It is the direct consumer of the core's `cp0_addr`/`cp0_we`/`exlset`/`exlclr`/`pc_` outputs. It also produces the core's `cp0_rd`, `epc` and `int_req_sel` inputs.

## Interface
- PRID_VAL, 32'h1830_0001, constant returned by register 15
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- cp0_addr  in  5  register select (core's rd field)
- din  in  32  mtc0 write data (core's busB)
- cp0_we  in  1  mtc0 write strobe
- exlset  in  1  interrupt entry: set EXL, capture EPC
- exlclr  in  1  eret: clear EXL
- pc  in  32  core PC, captured into EPC on exlset
- hwint  in  6  level-sensitive device interrupt lines, synchronous to clk
- dout  out  32  mfc0 read data
- epc  out  32  EPC register value
- int_req  out  1  interrupt request to controller

## Operation
- Register map, by cp0_addr:
  - 9 COUNT
  - 11 COMPARE
  - 12 SR: IM[15:10], EXL[1], IE[0]; other bits read 0
  - 13 CAUSE: TI[30], IP[15:10]; other bits 0
  - 14 EPC
  - 15 PRID
- Unmapped addresses read 0 and ignore writes.
- Writes to CAUSE and PRID are ignored.
- dout is combinational from cp0_addr and current register state.
- IP[15:10] is registered every cycle: IP <= hwint | {TI,5'b0}. The timer shares line 5.
- int_req = IE & ~EXL & |(IP & IM), combinational from registers.
- exlset: EXL <= 1; EPC <= {pc[31:2],2'b00}.
- exlclr: EXL <= 0.
- exlset and exlclr in the same cycle: exlset wins.
- mtc0 to SR in the same cycle as exlset/exlclr:
  - IM and IE take din.
  - EXL follows exlset/exlclr; din[1] is used only if neither is asserted.
- mtc0 to EPC in the same cycle as exlset: exlset value wins.
- COUNT: free-running, +1 per cycle, wraps 32'hFFFF_FFFF -> 0.
- mtc0 to COUNT loads din; there is no increment in that cycle.
- COMPARE: written by mtc0. Any COMPARE write clears TI.
- Timer match: when COUNT == COMPARE and COMPARE != 0, TI <= 1. TI holds until the next COMPARE write.
- COMPARE write and match in the same cycle: clear wins.

## Timing
- Reset (rst low, asynchronous) clears:
  - SR, CAUSE/IP, TI, EPC, COUNT and COMPARE to 0.
  - int_req to 0 and epc to 0.
  - dout to PRID_VAL if cp0_addr==15, else 0.
- Reset asserted mid-operation overrides every pending write.
- hwint rise at edge N-1..N: IP updates at edge N; int_req is high after edge N when unmasked.
  - Latency: 1 cycle.
- hwint fall: IP and int_req drop one cycle later. No latching; devices hold their lines until serviced.
- mtc0 takes effect at the strobe's edge. mfc0 of the same register in the next cycle returns the new value.
- exlset at edge N: int_req is low after edge N, and epc is valid after edge N.
- Timer:
  - COUNT equals COMPARE during cycle K; TI sets at the end of K.
  - IP[15] sets one edge later; int_req rises two edges after the match cycle.

## Structure
- Package cp0_pkg holds:
  - Register address constants: 9, 11, 12, 13, 14, 15.
  - Bit-position constants for IM, EXL, IE, IP and TI.
  - PRID default.
- Sub-module cp0_timer holds COUNT, COMPARE and TI.
  - Ports: clk, rst, we_count, we_compare, din, count, compare, ti.
- Top level holds SR, CAUSE, EPC, the read mux and the int_req logic.
- Expected size: ~180 lines of RTL.

## Test plan
- Reset: release rst, read addrs 12/13/14/15 -> 0, 0, 0, 32'h1830_0001; int_req=0.
- Masking:
  - Write SR=32'h0000_0401 (IM[10], IE), then drive hwint=6'b000001 -> int_req high one cycle later.
  - Repeat with IM bit clear -> int_req stays 0.
- Interrupt entry:
  - Pulse exlset with pc=32'h0000_3018 -> epc=32'h0000_3018, SR bit1=1, int_req=0 while hwint held.
  - Pulse exlclr -> int_req high again.
- Priorities:
  - exlset+exlclr together -> EXL=1.
  - mtc0 EPC=32'h1234 with exlset, pc=32'h3000 -> epc=32'h3000.
- Timer:
  - SR=32'h0000_8001; COUNT=0; COMPARE=10.
  - Check: CAUSE[30] sets after COUNT reaches 10; int_req follows one cycle later.
  - Write COMPARE=20 -> TI and int_req clear.
- Wrap and unmapped:
  - COUNT=32'hFFFF_FFFE -> reads 32'hFFFF_FFFF, then 0.
  - Write addr 3 -> reads 0; writes to CAUSE/PRID leave them unchanged.
